// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port nibble work RAM between the CPU register
// datapath and one secondary requester (LCD scanout, debug/savestate port).
// The CPU owns the RAM in its register fetch/write microcode cycles; the
// secondary port uses the remaining cycles through a req/ack handshake, and a
// bounded-wait counter stalls the CPU when the secondary port is starved.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no secondary access in flight; may issue in a free slot
// S_RESP | secondary access issued last cycle; RAM data returns, ack
module ram_arbiter #(
    parameter int         ADDR_WIDTH      = 12,
    parameter int         DATA_WIDTH      = 4,
    parameter int         MAX_WAIT        = 8,
    parameter logic [1:0] CYCLE_REG_FETCH = 2'd1,
    parameter logic [1:0] CYCLE_REG_WRITE = 2'd3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_current_cycle,
    input  logic                  i_cpu_halt,
    input  logic                  i_cpu_write_en,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_write_data,
    output logic [DATA_WIDTH-1:0] o_cpu_read_data,
    input  logic                  i_sec_req,
    input  logic                  i_sec_we,
    input  logic [ADDR_WIDTH-1:0] i_sec_addr,
    input  logic [DATA_WIDTH-1:0] i_sec_wdata,
    output logic                  o_sec_ack,
    output logic [DATA_WIDTH-1:0] o_sec_rdata,
    output logic                  o_cpu_stall,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_we,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    // Counter holds 0..MAX_WAIT inclusive (saturates at MAX_WAIT).
    localparam int              WCW       = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_MAX  = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WCW-1:0]        r_wait_cnt;
    logic                  r_cpu_stall;
    logic                  r_cpu_slot_d;
    logic [DATA_WIDTH-1:0] r_cpu_hold;
    logic                  r_sec_rd;
    logic [DATA_WIDTH-1:0] r_sec_hold;

    logic                  w_cpu_slot;
    logic                  w_issue;
    logic                  w_wait;

    // A stalled or halted CPU gives up its slot so the secondary can issue.
    assign w_cpu_slot = !i_cpu_halt && !r_cpu_stall &&
                        ((i_current_cycle == CYCLE_REG_FETCH) ||
                         (i_current_cycle == CYCLE_REG_WRITE));
    assign w_issue    = (r_state == S_IDLE) && i_sec_req && !w_cpu_slot;
    assign w_wait     = (r_state == S_IDLE) && i_sec_req &&  w_cpu_slot;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and RAM port mux; the CPU slot always has priority.
    always_comb begin
        w_state_nxt = r_state;
        o_ram_addr  = i_cpu_addr;
        o_ram_we    = 1'b0;
        o_ram_wdata = i_cpu_write_data;
        case (r_state)
            S_IDLE: if (w_issue) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_cpu_slot) begin
            o_ram_we = i_cpu_write_en;
        end else if (w_issue) begin
            o_ram_addr  = i_sec_addr;
            o_ram_we    = i_sec_we;
            o_ram_wdata = i_sec_wdata;
        end
    end

    // Starvation tracking: count CPU-blocked request cycles, stall the CPU
    // once the budget is used so the very next cycle is free for the issue.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt  <= '0;
            r_cpu_stall <= 1'b0;
        end else if (w_issue) begin
            r_wait_cnt  <= '0;
            r_cpu_stall <= 1'b0;
        end else if (w_wait) begin
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt >= WAIT_LAST) r_cpu_stall <= 1'b1;
        end else if ((r_state == S_IDLE) && !i_sec_req) begin
            // Request withdrawn before issue: abort, release any stall.
            r_wait_cnt  <= '0;
            r_cpu_stall <= 1'b0;
        end
    end

    // CPU read path: a hold register keeps CPU-visible data stable across
    // secondary accesses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_slot_d <= 1'b0;
            r_cpu_hold   <= '0;
        end else begin
            r_cpu_slot_d <= w_cpu_slot;
            if (r_cpu_slot_d) r_cpu_hold <= i_ram_rdata;
        end
    end

    // Secondary read path: remember the access type at issue, capture the
    // returning data at the end of RESP so it stays valid after the ack.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sec_rd   <= 1'b0;
            r_sec_hold <= '0;
        end else begin
            if (w_issue) r_sec_rd <= !i_sec_we;
            if ((r_state == S_RESP) && r_sec_rd) r_sec_hold <= i_ram_rdata;
        end
    end

    assign o_cpu_read_data = r_cpu_slot_d ? i_ram_rdata : r_cpu_hold;
    assign o_sec_ack       = (r_state == S_RESP);
    assign o_sec_rdata     = ((r_state == S_RESP) && r_sec_rd) ? i_ram_rdata : r_sec_hold;
    assign o_cpu_stall     = r_cpu_stall;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WRITE = 2'd3;
    localparam logic [1:0] FREE  = 2'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cur_cycle;
    logic        cpu_halt, cpu_we;
    logic [11:0] cpu_addr;
    logic [3:0]  cpu_wdata, cpu_rdata;
    logic        sec_req, sec_we;
    logic [11:0] sec_addr;
    logic [3:0]  sec_wdata, sec_rdata;
    logic        sec_ack, cpu_stall;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata, ram_rdata;

    logic        bd_we;
    logic [11:0] bd_addr;
    logic [3:0]  bd_data;
    logic [3:0]  mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .i_clk(clk), .i_reset(rst), .i_current_cycle(cur_cycle),
        .i_cpu_halt(cpu_halt), .i_cpu_write_en(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_write_data(cpu_wdata), .o_cpu_read_data(cpu_rdata),
        .i_sec_req(sec_req), .i_sec_we(sec_we), .i_sec_addr(sec_addr),
        .i_sec_wdata(sec_wdata), .o_sec_ack(sec_ack), .o_sec_rdata(sec_rdata),
        .o_cpu_stall(cpu_stall), .o_ram_addr(ram_addr), .o_ram_we(ram_we),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    // Single-port synchronous RAM, read-before-write, with a preload port.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic preload(input logic [11:0] a, input logic [3:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cur_cycle = FREE; cpu_halt = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; sec_req = 1'b0; sec_we = 1'b0;
        sec_addr = '0; sec_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", sec_ack); end
        n_cmp++; if (sec_rdata !== 4'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", sec_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        n_cmp++; if (cpu_rdata !== 4'h0) begin n_err++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_sec_read();
        preload(12'h123, 4'hA);
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 12'h123;
        #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rd_issue_we got %b want 0", ram_we); end
        n_cmp++; if (ram_addr !== 12'h123) begin n_err++; $display("FAIL rd_issue_addr got %h want 123", ram_addr); end
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL rd_early_ack got %b want 0", sec_ack); end
        @(negedge clk);
        sec_req = 1'b0;
        n_cmp++; if (sec_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b want 1", sec_ack); end
        n_cmp++; if (sec_rdata !== 4'hA) begin n_err++; $display("FAIL rd_data got %h want a", sec_rdata); end
        n_cmp++; if (cpu_rdata !== 4'h0) begin n_err++; $display("FAIL rd_cpu_unchanged got %h want 0", cpu_rdata); end
        @(negedge clk);
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse got %b want 0", sec_ack); end
        n_cmp++; if (sec_rdata !== 4'hA) begin n_err++; $display("FAIL rd_data_held got %h want a", sec_rdata); end
    endtask

    task automatic test_contention();
        @(negedge clk);
        cur_cycle = FETCH; cpu_we = 1'b1; cpu_addr = 12'h040; cpu_wdata = 4'h3;
        sec_req = 1'b1; sec_we = 1'b1; sec_addr = 12'h040; sec_wdata = 4'h5;
        #1;
        n_cmp++; if (ram_wdata !== 4'h3 || ram_we !== 1'b1) begin n_err++; $display("FAIL cont_cpu_first got we=%b d=%h want we=1 d=3", ram_we, ram_wdata); end
        @(negedge clk);
        n_cmp++; if (mem[12'h040] !== 4'h3) begin n_err++; $display("FAIL cont_cpu_landed got %h want 3", mem[12'h040]); end
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL cont_no_ack got %b want 0", sec_ack); end
        cur_cycle = FREE; cpu_we = 1'b0;
        #1;
        n_cmp++; if (ram_wdata !== 4'h5 || ram_we !== 1'b1 || ram_addr !== 12'h040) begin n_err++; $display("FAIL cont_sec_issue got we=%b a=%h d=%h want we=1 a=040 d=5", ram_we, ram_addr, ram_wdata); end
        @(negedge clk);
        sec_req = 1'b0; sec_we = 1'b0;
        n_cmp++; if (sec_ack !== 1'b1) begin n_err++; $display("FAIL cont_ack got %b want 1", sec_ack); end
        n_cmp++; if (mem[12'h040] !== 4'h5) begin n_err++; $display("FAIL cont_ram got %h want 5", mem[12'h040]); end
    endtask

    task automatic test_cpu_isolation();
        preload(12'h010, 4'h7);
        preload(12'h020, 4'h2);
        cur_cycle = FETCH; cpu_we = 1'b0; cpu_addr = 12'h010;
        @(negedge clk);
        cur_cycle = FREE;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 12'h020;
        #1;
        n_cmp++; if (cpu_rdata !== 4'h7) begin n_err++; $display("FAIL iso_cpu_read got %h want 7", cpu_rdata); end
        @(negedge clk);
        sec_req = 1'b0;
        n_cmp++; if (sec_rdata !== 4'h2) begin n_err++; $display("FAIL iso_sec_data got %h want 2", sec_rdata); end
        n_cmp++; if (cpu_rdata !== 4'h7) begin n_err++; $display("FAIL iso_cpu_during_ack got %h want 7", cpu_rdata); end
        @(negedge clk);
        n_cmp++; if (cpu_rdata !== 4'h7) begin n_err++; $display("FAIL iso_cpu_after got %h want 7", cpu_rdata); end
    endtask

    task automatic test_abort();
        cur_cycle = FETCH; cpu_addr = 12'h000;
        sec_req = 1'b1; sec_we = 1'b1; sec_addr = 12'h300; sec_wdata = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++; if (dut.r_wait_cnt !== 4'd3) begin n_err++; $display("FAIL abort_wait got %0d want 3", dut.r_wait_cnt); end
        sec_req = 1'b0; cur_cycle = FREE;
        #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL abort_no_write got %b want 0", ram_we); end
        @(negedge clk);
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL abort_no_ack got %b want 0", sec_ack); end
        n_cmp++; if (dut.r_wait_cnt !== 4'd0) begin n_err++; $display("FAIL abort_wait_clr got %0d want 0", dut.r_wait_cnt); end
        sec_we = 1'b0;
    endtask

    task automatic test_starvation();
        preload(12'h0AB, 4'hC);
        cur_cycle = FETCH; cpu_we = 1'b0; cpu_addr = 12'h000;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 12'h0AB;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            cur_cycle = (n % 2 == 1) ? WRITE : FETCH;
            n_cmp++; if (cpu_stall !== 1'b0 || sec_ack !== 1'b0) begin n_err++; $display("FAIL starve_wait%0d got stall=%b ack=%b want 0 0", n, cpu_stall, sec_ack); end
        end
        @(negedge clk);
        n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall got %b want 1", cpu_stall); end
        n_cmp++; if (dut.r_wait_cnt !== 4'd8) begin n_err++; $display("FAIL starve_cnt got %0d want 8", dut.r_wait_cnt); end
        #1;
        n_cmp++; if (ram_addr !== 12'h0AB) begin n_err++; $display("FAIL starve_issue got %h want 0ab", ram_addr); end
        @(negedge clk);
        sec_req = 1'b0; cur_cycle = FREE;
        n_cmp++; if (sec_ack !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_ack got ack=%b stall=%b want 1 0", sec_ack, cpu_stall); end
        n_cmp++; if (sec_rdata !== 4'hC) begin n_err++; $display("FAIL starve_data got %h want c", sec_rdata); end
        n_cmp++; if (dut.r_wait_cnt !== 4'd0) begin n_err++; $display("FAIL starve_cnt_clr got %0d want 0", dut.r_wait_cnt); end
    endtask

    task automatic test_back_to_back();
        preload(12'h000, 4'h9);
        preload(12'h001, 4'h6);
        cpu_halt = 1'b1; cur_cycle = FETCH;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 12'h000;
        @(negedge clk);
        sec_req = 1'b0;
        n_cmp++; if (sec_ack !== 1'b1 || sec_rdata !== 4'h9) begin n_err++; $display("FAIL b2b_first got ack=%b d=%h want 1 9", sec_ack, sec_rdata); end
        @(negedge clk);
        sec_req = 1'b1; sec_addr = 12'h001;
        n_cmp++; if (sec_ack !== 1'b0) begin n_err++; $display("FAIL b2b_gap got %b want 0", sec_ack); end
        @(negedge clk);
        sec_req = 1'b0;
        n_cmp++; if (sec_ack !== 1'b1 || sec_rdata !== 4'h6) begin n_err++; $display("FAIL b2b_second got ack=%b d=%h want 1 6", sec_ack, sec_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %b want 0", cpu_stall); end
        cpu_halt = 1'b0; cur_cycle = FREE;
    endtask

    task automatic test_reset_in_resp();
        preload(12'h055, 4'hE);
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 12'h055;
        @(negedge clk);
        n_cmp++; if (sec_ack !== 1'b1) begin n_err++; $display("FAIL rr_in_resp got %b want 1", sec_ack); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sec_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL rr_async got ack=%b stall=%b want 0 0", sec_ack, cpu_stall); end
        n_cmp++; if (sec_rdata !== 4'h0) begin n_err++; $display("FAIL rr_rdata_clr got %h want 0", sec_rdata); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sec_req = 1'b0;
        n_cmp++; if (sec_ack !== 1'b1 || sec_rdata !== 4'hE) begin n_err++; $display("FAIL rr_reservice got ack=%b d=%h want 1 e", sec_ack, sec_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sec_read();
        test_contention();
        test_cpu_isolation();
        test_abort();
        test_starvation();
        test_back_to_back();
        test_reset_in_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
